// File: rtl/i2s_tx.sv
// i2s_tx: I2S / left-justified stereo serialiser with sample FIFO.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   enable, fmt        run enable; 0 = I2S, 1 = left-justified
//   s_valid/s_ready    stereo sample handshake, s_left/s_right data
//   fifo_level         occupied FIFO entries
//   underrun           pulse on a frame start with an empty FIFO
//   underrun_cnt       saturating underrun count
//   MCLK, BCLK, LRCLK, SDIN  codec-side clocks and data
// Build option: define I2S_TX_UNDERRUN_CNT_EN to implement the
// underrun counter; otherwise underrun_cnt is tied to 0.
module i2s_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4,
  parameter int MCLK_DIV = 1,
  parameter int FIFO_AW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                fmt,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                underrun,
  output logic [15:0]         underrun_cnt,
  output logic                MCLK,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDIN
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = 2 * SLOT_W;
  localparam int PAD   = SLOT_W - SAMPLE_W;
  localparam logic [6:0] BIT_MAX = 7'(FW - 1);
  localparam logic [6:0] SLOT_L  = 7'(SLOT_W);
  localparam logic [15:0] BDIV   = 16'(BCLK_DIV - 1);
  localparam logic [15:0] MDIV   = 16'(MCLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_N = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state;

  logic [2*SAMPLE_W-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wptr;
  logic [FIFO_AW-1:0]    rptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  logic [15:0]           mclk_cnt;
  logic [15:0]           div_cnt;
  logic [6:0]            bit_cnt;
  logic [FW-1:0]         sr;
  logic                  fmt_r;

  logic                  tick;
  logic                  fall;
  logic                  wrap;
  logic                  start;
  logic [2*SAMPLE_W-1:0] ld;
  logic [SLOT_W-1:0]     l_slot;
  logic [SLOT_W-1:0]     r_slot;
  logic [FW-1:0]         ld_sr;

  assign full    = fifo_level == FULL_N;
  assign empty   = fifo_level == '0;
  assign s_ready = !rst && !full;
  assign push    = s_valid && s_ready;

  assign tick  = (state == RUN) && (div_cnt == BDIV);
  assign fall  = tick && BCLK;
  assign wrap  = fall && (bit_cnt == BIT_MAX);
  assign start = enable && ((state == IDLE) || wrap);
  assign pop   = start && !empty;

  // Underrun frames shift out zeros; slots pad below the sample.
  assign ld     = empty ? '0 : mem[rptr];
  assign l_slot = SLOT_W'(ld[2*SAMPLE_W-1:SAMPLE_W]) << PAD;
  assign r_slot = SLOT_W'(ld[SAMPLE_W-1:0]) << PAD;
  assign ld_sr  = {l_slot, r_slot};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {s_left, s_right};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop)  rptr <= rptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt <= '0;
      MCLK     <= 1'b0;
    end else if (mclk_cnt == MDIV) begin
      mclk_cnt <= '0;
      MCLK     <= !MCLK;
    end else begin
      mclk_cnt <= mclk_cnt + 16'd1;
    end
  end

  // sr[FW-1] is always the left-justified bit of the current BCLK
  // period; I2S mode outputs it one period late, so the last bit of
  // a frame lands in bit 0 of the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      BCLK     <= 1'b0;
      LRCLK    <= 1'b0;
      SDIN     <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      fmt_r    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= start && empty;
      case (state)
        IDLE: begin
          BCLK    <= 1'b0;
          LRCLK   <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (enable) begin
            state <= RUN;
            sr    <= ld_sr;
            fmt_r <= fmt;
            SDIN  <= fmt ? ld_sr[FW-1] : sr[FW-1];
          end else begin
            sr   <= '0;
            SDIN <= 1'b0;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            BCLK    <= 1'b0;
            LRCLK   <= 1'b0;
            SDIN    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
          end else begin
            div_cnt <= tick ? '0 : div_cnt + 16'd1;
            if (tick) BCLK <= !BCLK;
            if (wrap) begin
              bit_cnt <= '0;
              LRCLK   <= 1'b0;
              sr      <= ld_sr;
              fmt_r   <= fmt;
              SDIN    <= fmt ? ld_sr[FW-1] : sr[FW-1];
            end else if (fall) begin
              bit_cnt <= bit_cnt + 7'd1;
              LRCLK   <= (bit_cnt + 7'd1) >= SLOT_L;
              sr      <= {sr[FW-2:0], 1'b0};
              SDIN    <= fmt_r ? sr[FW-2] : sr[FW-1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ur_cnt <= '0;
    end else if (start && empty && (ur_cnt != 16'hFFFF)) begin
      ur_cnt <= ur_cnt + 16'd1;
    end
  end

  assign underrun_cnt = ur_cnt;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx.
// Table-driven FIFO vectors plus frame-level stream model.
module tb_i2s_tx;

  localparam int SW = 16;
  localparam int SL = 16;
  localparam int FA = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic fmt = 1'b0;
  logic s_valid = 1'b0;
  logic [SW-1:0] s_left = '0;
  logic [SW-1:0] s_right = '0;
  wire s_ready;
  wire [FA:0] fifo_level;
  wire underrun;
  wire [15:0] underrun_cnt;
  wire MCLK, BCLK, LRCLK, SDIN;

  logic p_enable = 1'b0;
  logic p_fmt = 1'b1;
  logic p_valid = 1'b0;
  logic [23:0] p_left = '0;
  logic [23:0] p_right = '0;
  wire p_ready;
  wire [3:0] p_level;
  wire p_ur;
  wire [15:0] p_ucnt;
  wire p_mclk, p_bclk, p_lrclk, p_sdin;

  always #5 clk = ~clk;

  i2s_tx #(
    .SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(2),
    .MCLK_DIV(1), .FIFO_AW(FA)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fmt(fmt),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right),
    .fifo_level(fifo_level), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .MCLK(MCLK), .BCLK(BCLK),
    .LRCLK(LRCLK), .SDIN(SDIN)
  );

  i2s_tx #(
    .SAMPLE_W(24), .SLOT_W(32), .BCLK_DIV(2),
    .MCLK_DIV(1), .FIFO_AW(3)
  ) pdut (
    .clk(clk), .rst(rst), .enable(p_enable), .fmt(p_fmt),
    .s_valid(p_valid), .s_ready(p_ready),
    .s_left(p_left), .s_right(p_right),
    .fifo_level(p_level), .underrun(p_ur),
    .underrun_cnt(p_ucnt), .MCLK(p_mclk), .BCLK(p_bclk),
    .LRCLK(p_lrclk), .SDIN(p_sdin)
  );

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          exp_ready;
    logic [FA:0]   exp_lvl;
  } vec_t;

  vec_t tbl [9];

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  bit bq [$];
  bit lq [$];
  bit pq [$];
  int uq [$];
  int rq [$];
  logic pb = 1'b0;
  logic ppb = 1'b0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (BCLK && !pb) begin
      bq.push_back(SDIN);
      lq.push_back(LRCLK);
      rq.push_back(cyc);
    end
    if (p_bclk && !ppb) pq.push_back(p_sdin);
    if (underrun) uq.push_back(cyc);
    pb  = BCLK;
    ppb = p_bclk;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic clear_q();
    bq.delete();
    lq.delete();
    pq.delete();
    uq.delete();
    rq.delete();
  endtask

  task automatic push(logic [SW-1:0] l, logic [SW-1:0] r);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    tick();
    s_valid = 1'b0;
  endtask

  function automatic logic [31:0] word_at(bit q [$], int base);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (base + i < q.size()) w[31-i] = q[base+i];
      else w[31-i] = 1'bx;
    end
    return w;
  endfunction

  // Left-justified frame: left slot then right slot, MSB first,
  // each sample left-aligned in its slot.
  function automatic logic [31:0] lj_frame(logic [SW-1:0] l,
                                           logic [SW-1:0] r);
    logic [63:0] v;
    v = (64'(l) << (2*SL - SW)) | (64'(r) << (SL - SW));
    return v[31:0];
  endfunction

  // I2S: the left-justified stream delayed by one bit period.
  function automatic logic [31:0] i2s_frame(logic [31:0] cur,
                                            logic prev_last);
    return {prev_last, cur[31:1]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] rl [3];
    logic [SW-1:0] rr [3];
    logic [31:0] w [8];
    logic [SW-1:0] al, ar, bl, br;
    logic [23:0] pr;
    logic [31:0] exp_w;
    int c0;
    int t;
    logic z;

    for (int i = 0; i < 9; i++) begin
      tbl[i].l = SW'($urandom);
      tbl[i].r = SW'($urandom);
      tbl[i].exp_ready = (i < 8);
      tbl[i].exp_lvl = (i < 8) ? (FA+1)'(i + 1) : (FA+1)'(8);
    end

    // Reset with enable held high.
    rst = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_outs",
          {s_ready, fifo_level, underrun, underrun_cnt,
           MCLK, BCLK, LRCLK, SDIN}, 64'd0);
    end
    rst = 1'b0;
    enable = 1'b0;
    #1;
    chk("ready_after_rst", s_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("mclk", MCLK, k % 2);
    end
    chk("idle_bclk", BCLK, 0);

    // Left-justified frame.
    fmt = 1'b1;
    push(16'hA5F0, 16'h0F5A);
    chk("lvl_one", fifo_level, 1);
    clear_q();
    c0 = cyc;
    enable = 1'b1;
    tick();
    chk("lvl_after_pop", fifo_level, 0);
    chk("no_ur_first", underrun, 0);
    run(129);
    chk("first_rise", rq.size() > 0 ? rq[0] - c0 : -1, 3);
    chk("lj_data", word_at(bq, 0),
        lj_frame(16'hA5F0, 16'h0F5A));
    chk("lj_lrclk", word_at(lq, 0), 32'h0000FFFF);
    chk("lj_frame_len", uq.size() > 0 ? uq[0] - c0 : -1, 129);
    enable = 1'b0;
    tick();
    chk("off_outs", {BCLK, LRCLK, SDIN}, 0);

    // I2S frame, same data.
    fmt = 1'b0;
    push(16'hA5F0, 16'h0F5A);
    clear_q();
    enable = 1'b1;
    run(260);
    exp_w = lj_frame(16'hA5F0, 16'h0F5A);
    chk("i2s_f0", word_at(bq, 0), i2s_frame(exp_w, 1'b0));
    chk("i2s_f1", word_at(bq, 32), i2s_frame(32'd0, exp_w[0]));
    enable = 1'b0;
    tick();

    // Random multi-frame streams in both formats.
    for (int m = 0; m < 2; m++) begin
      fmt = m[0];
      for (int i = 0; i < 3; i++) begin
        rl[i] = SW'($urandom);
        rr[i] = SW'($urandom);
        push(rl[i], rr[i]);
      end
      clear_q();
      c0 = cyc;
      enable = 1'b1;
      run(3*128 + 8);
      for (int f = 0; f < 3; f++) begin
        exp_w = lj_frame(rl[f], rr[f]);
        if (m == 0) begin
          z = (f == 0) ? 1'b0 : lj_frame(rl[f-1], rr[f-1]) & 1;
          exp_w = i2s_frame(exp_w, z);
        end
        chk("rand_frame", word_at(bq, 32*f), exp_w);
      end
      if (m == 0) begin
        exp_w = lj_frame(rl[2], rr[2]);
        chk("i2s_carry", bq.size() > 96 ? bq[96] : 1'bx,
            exp_w[0]);
      end
      chk("rand_ur", uq.size() > 0 ? uq[0] - c0 : -1, 385);
      enable = 1'b0;
      tick();
    end

    // Enable drop mid right slot; push and pop in one cycle.
    fmt = 1'b1;
    al = SW'($urandom);
    ar = SW'($urandom);
    bl = SW'($urandom);
    br = SW'($urandom);
    push(al, ar);
    s_valid = 1'b1;
    s_left = bl;
    s_right = br;
    enable = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("push_pop_lvl", fifo_level, 1);
    t = 0;
    while (!LRCLK && t < 200) begin
      tick();
      t++;
    end
    chk("lrclk_seen", LRCLK, 1);
    run(10);
    enable = 1'b0;
    tick();
    chk("drop_outs", {BCLK, LRCLK, SDIN}, 0);
    chk("drop_lvl", fifo_level, 1);
    run(5);
    clear_q();
    enable = 1'b1;
    tick();
    chk("reen_pop", fifo_level, 0);
    run(129);
    chk("reen_data", word_at(bq, 0), lj_frame(bl, br));
    enable = 1'b0;
    tick();

    // Backpressure table, then drain to underrun.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_left = tbl[i].l;
      s_right = tbl[i].r;
      #1;
      chk("tbl_ready", s_ready, tbl[i].exp_ready);
      tick();
      chk("tbl_level", fifo_level, tbl[i].exp_lvl);
    end
    // Full FIFO with a pop in the same cycle: no push taken.
    clear_q();
    c0 = cyc;
    enable = 1'b1;
    #1;
    chk("full_pop_ready", s_ready, 0);
    tick();
    s_valid = 1'b0;
    chk("full_pop_lvl", fifo_level, 7);
    run(8*128 + 40);
    for (int f = 0; f < 8; f++) begin
      w[f] = lj_frame(tbl[f].l, tbl[f].r);
      chk("drain_frame", word_at(bq, 32*f), w[f]);
    end
    chk("ur_cycle", uq.size() > 0 ? uq[0] - c0 : -1, 1025);
    chk("ur_once", uq.size(), 1);
    z = 1'b0;
    for (int i = 256; i < 264; i++)
      z = z | (i < bq.size() ? bq[i] : 1'b1);
    chk("ur_sdin_zero", z, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("ur_cnt", underrun_cnt, 1);
`else
    chk("ur_cnt", underrun_cnt, 0);
`endif
    chk("drained_ready", s_ready, 1);
    enable = 1'b0;
    tick();

    // Slot padding: 24-bit samples in 32-bit slots.
    pr = 24'($urandom);
    p_valid = 1'b1;
    p_left = 24'h800001;
    p_right = pr;
    tick();
    p_valid = 1'b0;
    clear_q();
    p_enable = 1'b1;
    run(264);
    chk("pad_left", word_at(pq, 0), {24'h800001, 8'h00});
    chk("pad_right", word_at(pq, 32), {pr, 8'h00});
    p_enable = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
